tcb_arbiter: RTL and testbench
==============================

// Module: tcb_arbiter
// PURPOSE
//  Shares one TCB subordinate (e.g. the GPIO controller) between MN TCB managers.
//  - Sequential arbitration with a grant lock held across subordinate stalls.
//  - Fair round-robin pointer.
//  - Per-transfer ID pipeline routes each read response (rdt/err) back to its issuer.
//  - Sits between the CPU/debug/DMA data ports and a peripheral.
// PARAMETERS
//  MN   2       number of managers (2..8)
//  AW   15      address width (byte address)
//  DW   32      data width
//  BW   DW/8    byte enable width
//  DLY  1       subordinate response latency in cycles after transfer (1..4)
//  IW   $clog2(MN)  manager index width (derived, not overridable)
// PORTS
//  clk      in   1      clock
//  rst      in   1      reset, asynchronous, active low
//  man_vld  in   MN     per-manager valid
//  man_wen  in   MN     per-manager write enable
//  man_adr  in   MN*AW  per-manager address, manager i at [i*AW+:AW]
//  man_ben  in   MN*BW  per-manager byte enable
//  man_wdt  in   MN*DW  per-manager write data
//  man_rdt  out  MN*DW  per-manager read data
//  man_err  out  MN     per-manager error
//  man_rdy  out  MN     per-manager ready
//  sub_vld  out  1      subordinate valid
//  sub_wen  out  1      subordinate write enable
//  sub_adr  out  AW     subordinate address
//  sub_ben  out  BW     subordinate byte enable
//  sub_wdt  out  DW     subordinate write data
//  sub_rdt  in   DW     subordinate read data
//  sub_err  in   1      subordinate error
//  sub_rdy  in   1      subordinate ready
// BEHAVIOUR
//  - Transfer: sub_vld & sub_rdy in the same cycle. Request path is combinational (zero added latency).
//  - State: ptr[IW], lck (1b), lid[IW], resp pipeline of DLY stages {val, id}.
//  - Reset (rst=0): ptr=0, lck=0, lid=0, all pipeline val=0.
//    - Outputs during reset: sub_vld=0, man_rdy=0, man_err=0, man_rdt=0.
//  - Grant select, when lck=0: first i with man_vld[i]=1, searching (ptr, ptr+1, ..., ptr+MN-1) mod MN.
//  - Grant select, when lck=1: the grant is lid, regardless of the other valids.
//  - sub_* = granted manager's request fields; sub_vld = |man_vld.
//  - man_rdy[g] = sub_rdy for the granted g; man_rdy[others] = 0.
//  - Stall (sub_vld & ~sub_rdy): lck<=1, lid<=g. The grant cannot move while the granted request waits.
//  - Transfer: lck<=0; ptr<=(g+1) mod MN (wrap from MN-1 to 0).
//  - Idle (sub_vld=0): ptr, lck unchanged.
//    - lck=1 with man_vld[lid]=0 is a manager protocol violation: clear lck; assert in sim.
//  - Response pipeline:
//    - Stage0 <= {transfer, g}; stage k <= stage k-1.
//    - Stage DLY-1 valid with id=j: man_rdt[j]=sub_rdt, man_err[j]=sub_err.
//    - All other managers: rdt=0, err=0.
//  - Back-to-back transfers from different managers each cycle: every response is routed to its own issuer.
//  - Mid-operation reset clears the pipeline; in-flight responses are dropped (not routed).
//  - sub_err is passed through only; the arbiter never generates errors itself.
// CONFIGURATION
//  TCB_ARBITER_FIXED_PRIORITY_EN
//  - Defined: ptr is held at 0 (fixed priority, manager 0 highest); the stall lock still applies.
//  - Undefined: round-robin as above.
// TESTING
//  1. Reset: rst=0 with all man_vld=1.
//     -> sub_vld=0, man_rdy=0. After release with sub_rdy=1 -> first grant to manager 0.
//  2. MN=2, both valid continuously, sub_rdy=1.
//     -> grants alternate 0,1,0,1; man_rdy toggles each cycle.
//     -> With FIXED_PRIORITY_EN: manager 0 every cycle.
//  3. Manager 1 valid alone, sub_rdy=0 for 3 cycles; manager 0 raises vld in cycle 2.
//     -> sub_adr stays at manager 1 for 4 cycles; manager 0 is granted after the transfer.
//  4. DLY=2, manager 0 reads adr 0x004, then manager 1 reads adr 0x008; sub returns 0xAAAA_0000 then 0x5555_0000.
//     -> man_rdt[0]=0xAAAA_0000 at t+2; man_rdt[1]=0x5555_0000 at t+3; non-selected managers read 0.
//  5. sub_err=1 on manager 1's response -> man_err=2'b10 for exactly one cycle.
//  6. Assert rst during a DLY=2 read in flight -> no man_rdt/man_err activity after release.

Source files
------------

// File: rtl/tcb_arbiter.sv
// Shares one TCB subordinate between MN managers: round-robin grant with a stall lock,
// plus an ID pipeline that routes each response to its issuer. Option: TCB_ARBITER_FIXED_PRIORITY_EN.
module tcb_arbiter #(
    parameter int MN  = 2,
    parameter int AW  = 15,
    parameter int DW  = 32,
    parameter int BW  = DW/8,
    parameter int DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MN-1:0]    man_vld,
    input  logic [MN-1:0]    man_wen,
    input  logic [MN*AW-1:0] man_adr,
    input  logic [MN*BW-1:0] man_ben,
    input  logic [MN*DW-1:0] man_wdt,
    output logic [MN*DW-1:0] man_rdt,
    output logic [MN-1:0]    man_err,
    output logic [MN-1:0]    man_rdy,
    output logic             sub_vld,
    output logic             sub_wen,
    output logic [AW-1:0]    sub_adr,
    output logic [BW-1:0]    sub_ben,
    output logic [DW-1:0]    sub_wdt,
    input  logic [DW-1:0]    sub_rdt,
    input  logic             sub_err,
    input  logic             sub_rdy
);
    localparam int IW = (MN > 1) ? $clog2(MN) : 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_lid;
    logic          r_lck;

    logic [IW-1:0] w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_found;
    logic [IW-1:0] w_ptr_next;
    logic          w_xfer;
    logic          w_stall;
    logic          w_viol;
    logic          w_rsp_v;
    logic [IW-1:0] w_rsp_id;

    // A locked grant ignores every other valid; otherwise search upward from the pointer.
    always_comb begin
        w_gnt   = r_ptr;
        w_idx   = '0;
        w_found = 1'b0;
        if (r_lck) begin
            w_gnt = r_lid;
        end else begin
            for (int k = 0; k < MN; k++) begin
                w_idx = IW'((int'(r_ptr) + k) % MN);
                if (!w_found && man_vld[w_idx]) begin
                    w_gnt   = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

`ifdef TCB_ARBITER_FIXED_PRIORITY_EN
    assign w_ptr_next = '0;
`else
    assign w_ptr_next = (w_gnt == IW'(MN-1)) ? '0 : w_gnt + IW'(1);
`endif

    assign sub_vld = rst & (|man_vld);
    assign sub_wen = man_wen[w_gnt];
    assign sub_adr = man_adr[w_gnt*AW +: AW];
    assign sub_ben = man_ben[w_gnt*BW +: BW];
    assign sub_wdt = man_wdt[w_gnt*DW +: DW];

    assign w_xfer  = sub_vld & sub_rdy;
    assign w_stall = sub_vld & ~sub_rdy;
    assign w_viol  = r_lck & ~man_vld[r_lid];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_lck <= 1'b0;
            r_lid <= '0;
        end else if (w_viol) begin
            r_lck <= 1'b0;
        end else if (w_xfer) begin
            r_lck <= 1'b0;
            r_ptr <= w_ptr_next;
        end else if (w_stall) begin
            r_lck <= 1'b1;
            r_lid <= w_gnt;
        end
    end

`ifndef SYNTHESIS
    // A manager must keep its request up while it holds the lock.
    a_lock_held: assert property (@(posedge clk) disable iff (!rst) !w_viol);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DLY; gi++) begin : g_pipe
            logic          r_v;
            logic [IW-1:0] r_id;
            logic          w_v_in;
            logic [IW-1:0] w_id_in;
            if (gi == 0) begin : g_head
                assign w_v_in  = w_xfer;
                assign w_id_in = w_gnt;
            end else begin : g_body
                assign w_v_in  = g_pipe[gi-1].r_v;
                assign w_id_in = g_pipe[gi-1].r_id;
            end
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_v  <= 1'b0;
                    r_id <= '0;
                end else begin
                    r_v  <= w_v_in;
                    r_id <= w_id_in;
                end
            end
        end
    endgenerate

    assign w_rsp_v  = g_pipe[DLY-1].r_v;
    assign w_rsp_id = g_pipe[DLY-1].r_id;

    generate
        for (gi = 0; gi < MN; gi++) begin : g_man
            assign man_rdy[gi]             = rst & sub_rdy & (w_gnt == IW'(gi));
            assign man_rdt[gi*DW +: DW]    = (w_rsp_v && w_rsp_id == IW'(gi)) ? sub_rdt : '0;
            assign man_err[gi]             = w_rsp_v & (w_rsp_id == IW'(gi)) & sub_err;
        end
    endgenerate

endmodule

// File: tb/tb_tcb_arbiter.sv
// Self-checking bench for tcb_arbiter (MN=2, DLY=2): directed scenarios plus a randomized run
// against a queue-based reference model of grant order and response routing.
module tb_tcb_arbiter;
    localparam int MN  = 2;
    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int BW  = DW/8;
    localparam int DLY = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [MN-1:0]    man_vld = '0;
    logic [MN-1:0]    man_wen = '0;
    logic [MN*AW-1:0] man_adr = '0;
    logic [MN*BW-1:0] man_ben = '0;
    logic [MN*DW-1:0] man_wdt = '0;
    logic [MN*DW-1:0] man_rdt;
    logic [MN-1:0]    man_err;
    logic [MN-1:0]    man_rdy;
    logic             sub_vld;
    logic             sub_wen;
    logic [AW-1:0]    sub_adr;
    logic [BW-1:0]    sub_ben;
    logic [DW-1:0]    sub_wdt;
    logic [DW-1:0]    sub_rdt = '0;
    logic             sub_err = 1'b0;
    logic             sub_rdy = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct { int due; int id; } rsp_t;
    rsp_t rsp_q[$];
    int   m_ptr;
    int   m_hold;
    int   cyc;

    always #5 clk = ~clk;

    tcb_arbiter #(.MN(MN), .AW(AW), .DW(DW), .BW(BW), .DLY(DLY)) dut (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_wen(man_wen), .man_adr(man_adr), .man_ben(man_ben),
        .man_wdt(man_wdt), .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben),
        .sub_wdt(sub_wdt), .sub_rdt(sub_rdt), .sub_err(sub_err), .sub_rdy(sub_rdy)
    );

    task automatic set_mgr(input int i, input logic v, input logic [AW-1:0] a);
        man_vld[i]           = v;
        man_wen[i]           = 1'b0;
        man_adr[i*AW +: AW]  = a;
        man_ben[i*BW +: BW]  = '1;
        man_wdt[i*DW +: DW]  = $urandom;
    endtask

    task automatic apply_reset();
        man_vld = '0;
        sub_rdy = 1'b0;
        sub_err = 1'b0;
        sub_rdt = '0;
        rst     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        m_ptr   = 0;
        m_hold  = -1;
        cyc     = 0;
        rsp_q.delete();
    endtask

    task automatic test_reset();
        set_mgr(0, 1'b1, 15'h100);
        set_mgr(1, 1'b1, 15'h200);
        sub_rdy = 1'b1;
        rst     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (sub_vld !== 1'b0) begin bad++; $display("FAIL rst_sub_vld got=%b exp=0", sub_vld); end
        total++;
        if (man_rdy !== 2'b00) begin bad++; $display("FAIL rst_man_rdy got=%b exp=00", man_rdy); end
        total++;
        if (man_rdt !== '0 || man_err !== '0) begin
            bad++; $display("FAIL rst_resp got rdt=%h err=%b exp zero", man_rdt, man_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (sub_vld !== 1'b1 || man_rdy !== 2'b01 || sub_adr !== 15'h100) begin
            bad++; $display("FAIL rst_first_grant got vld=%b rdy=%b adr=%h exp 1/01/100", sub_vld, man_rdy, sub_adr);
        end
        @(posedge clk);
        #1;
        man_vld = '0;
        $display("test_reset done");
    endtask

    task automatic test_alternate();
        logic [MN-1:0] exp_rdy;
        int eg;
        apply_reset();
        set_mgr(0, 1'b1, 15'h010);
        set_mgr(1, 1'b1, 15'h020);
        sub_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
`ifdef TCB_ARBITER_FIXED_PRIORITY_EN
            eg = 0;
`else
            eg = c % 2;
`endif
            exp_rdy = MN'(1) << eg;
            total++;
            if (man_rdy !== exp_rdy || sub_adr !== (eg == 1 ? 15'h020 : 15'h010)) begin
                bad++; $display("FAIL alt_grant c=%0d got rdy=%b adr=%h exp rdy=%b", c, man_rdy, sub_adr, exp_rdy);
            end
            @(posedge clk);
            #1;
        end
        man_vld = '0;
        $display("test_alternate done");
    endtask

    task automatic test_stall();
        logic [MN-1:0] exp_rdy;
        logic [AW-1:0] exp_adr;
        apply_reset();
        set_mgr(1, 1'b1, 15'h030);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) set_mgr(0, 1'b1, 15'h040);
            if (c == 4) man_vld[1] = 1'b0;
            sub_rdy = (c >= 3);
            exp_adr = (c < 4) ? 15'h030 : 15'h040;
            exp_rdy = (c < 3) ? 2'b00 : (c == 3 ? 2'b10 : 2'b01);
            @(negedge clk);
            total++;
            if (sub_adr !== exp_adr || man_rdy !== exp_rdy) begin
                bad++; $display("FAIL stall_lock c=%0d got adr=%h rdy=%b exp adr=%h rdy=%b", c, sub_adr, man_rdy, exp_adr, exp_rdy);
            end
            @(posedge clk);
            #1;
        end
        man_vld = '0;
        $display("test_stall done");
    endtask

    task automatic test_resp_route();
        logic [MN*DW-1:0] exp_rdt;
        apply_reset();
        sub_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            man_vld = '0;
            if (c == 0) set_mgr(0, 1'b1, 15'h004);
            if (c == 1) set_mgr(1, 1'b1, 15'h008);
            case (c)
                2:       sub_rdt = 32'hAAAA_0000;
                3:       sub_rdt = 32'h5555_0000;
                default: sub_rdt = $urandom;
            endcase
            exp_rdt = '0;
            if (c == 2) exp_rdt[0*DW +: DW] = 32'hAAAA_0000;
            if (c == 3) exp_rdt[1*DW +: DW] = 32'h5555_0000;
            @(negedge clk);
            total++;
            if (man_rdt !== exp_rdt) begin
                bad++; $display("FAIL route_rdt c=%0d got=%h exp=%h", c, man_rdt, exp_rdt);
            end
            if (c < 2) begin
                total++;
                if (sub_adr !== (c == 0 ? 15'h004 : 15'h008)) begin
                    bad++; $display("FAIL route_adr c=%0d got=%h", c, sub_adr);
                end
            end
            @(posedge clk);
            #1;
        end
        man_vld = '0;
        $display("test_resp_route done");
    endtask

    task automatic test_error();
        logic [MN-1:0] exp_err;
        apply_reset();
        sub_rdy = 1'b1;
        sub_err = 1'b1;
        for (int c = 0; c < 4; c++) begin
            man_vld = '0;
            if (c == 0) set_mgr(1, 1'b1, 15'h00C);
            sub_rdt = $urandom;
            exp_err = (c == 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            total++;
            if (man_err !== exp_err) begin
                bad++; $display("FAIL err_route c=%0d got=%b exp=%b", c, man_err, exp_err);
            end
            @(posedge clk);
            #1;
        end
        sub_err = 1'b0;
        $display("test_error done");
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        sub_rdy = 1'b1;
        sub_err = 1'b1;
        sub_rdt = 32'hCAFE_F00D;
        set_mgr(0, 1'b1, 15'h004);
        @(posedge clk);
        #1;
        man_vld = '0;
        rst     = 1'b0;
        for (int c = 1; c < 6; c++) begin
            if (c == 2) rst = 1'b1;
            @(negedge clk);
            total++;
            if (man_rdt !== '0 || man_err !== '0) begin
                bad++; $display("FAIL inflight_drop c=%0d got rdt=%h err=%b exp zero", c, man_rdt, man_err);
            end
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        sub_err = 1'b0;
        $display("test_reset_inflight done");
    endtask

    function automatic int model_grant();
        if (m_hold >= 0) return m_hold;
        for (int k = 0; k < MN; k++) begin
            int i = (m_ptr + k) % MN;
            if (man_vld[i]) return i;
        end
        return m_ptr;
    endfunction

    task automatic test_random();
        logic [MN-1:0]    done;
        logic [MN-1:0]    exp_rdy;
        logic [MN*DW-1:0] exp_rdt;
        logic [MN-1:0]    exp_err;
        int g;
        apply_reset();
        man_vld = '0;
        done    = '0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < MN; i++) begin
                if (!man_vld[i] || done[i]) begin
                    set_mgr(i, 1'($urandom % 2), 15'($urandom));
                    man_wen[i] = 1'($urandom % 2);
                    man_ben[i*BW +: BW] = BW'($urandom);
                end
            end
            done    = '0;
            sub_rdy = ($urandom % 4) != 0;
            sub_rdt = $urandom;
            sub_err = ($urandom % 4) == 0;
            @(negedge clk);
            g = model_grant();
            total++;
            if (sub_vld !== (|man_vld)) begin
                bad++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, sub_vld, |man_vld);
            end
            if (|man_vld) begin
                exp_rdy = sub_rdy ? (MN'(1) << g) : '0;
                total++;
                if (man_rdy !== exp_rdy) begin
                    bad++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cyc, man_rdy, exp_rdy);
                end
                total++;
                if (sub_adr !== man_adr[g*AW +: AW] || sub_wen !== man_wen[g] ||
                    sub_ben !== man_ben[g*BW +: BW] || sub_wdt !== man_wdt[g*DW +: DW]) begin
                    bad++; $display("FAIL rnd_req cyc=%0d got adr=%h exp adr=%h (mgr %0d)", cyc, sub_adr, man_adr[g*AW +: AW], g);
                end
            end
            exp_rdt = '0;
            exp_err = '0;
            for (int q = rsp_q.size() - 1; q >= 0; q--) begin
                if (rsp_q[q].due == cyc) begin
                    exp_rdt[rsp_q[q].id*DW +: DW] = sub_rdt;
                    exp_err[rsp_q[q].id]          = sub_err;
                    rsp_q.delete(q);
                end
            end
            total++;
            if (man_rdt !== exp_rdt || man_err !== exp_err) begin
                bad++; $display("FAIL rnd_rsp cyc=%0d got rdt=%h err=%b exp rdt=%h err=%b", cyc, man_rdt, man_err, exp_rdt, exp_err);
            end
            if (|man_vld) begin
                if (sub_rdy) begin
                    rsp_q.push_back('{due: cyc + DLY, id: g});
                    done[g] = 1'b1;
                    m_hold  = -1;
`ifdef TCB_ARBITER_FIXED_PRIORITY_EN
                    m_ptr   = 0;
`else
                    m_ptr   = (g + 1) % MN;
`endif
                    $display("xfer cyc=%0d mgr=%0d adr=%h wen=%b", cyc, g, man_adr[g*AW +: AW], man_wen[g]);
                end else begin
                    m_hold = g;
                end
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        man_vld = '0;
        $display("test_random done");
    endtask

    initial begin
        m_ptr  = 0;
        m_hold = -1;
        cyc    = 0;
        test_reset();
        test_alternate();
        test_stall();
        test_resp_route();
        test_error();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
